// File: rtl/onchip_mem_dma_master_if.sv
// rtl/onchip_mem_dma_master_if.sv - Avalon-MM bus bundle between the DMA master and the on-chip RAM
//
// Purpose: groups the single-port on-chip RAM slave bus so the master and the
// memory side share one typed connection.
// Signals:
//   address    word address (ADDR_W)
//   byteenable byte lanes (DATA_W/8), driven all ones by the master
//   chipselect access strobe
//   write      1 = write access, 0 = read access
//   writedata  write data (DATA_W)
//   readdata   read data (DATA_W), valid one clock after a read strobe
// Modports: master (DMA side), slave (memory side).

interface onchip_mem_dma_master_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                chipselect;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;

   modport master (
      output address, byteenable, chipselect, write, writedata,
      input  readdata
   );

   modport slave (
      input  address, byteenable, chipselect, write, writedata,
      output readdata
   );
endinterface

// File: rtl/onchip_mem_dma_master.sv
// rtl/onchip_mem_dma_master.sv - block read/write DMA master for the on-chip RAM
//
// Purpose: executes one command at a time against the on-chip RAM: a sequential
// block read streamed out through a small return FIFO, or a sequential block
// write fed from an input stream.
// Optional feature: define DMA_CHECKSUM_EN to build the transfer checksum
// accumulator; otherwise checksum is tied to 0.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only when idle)
//   cmd_write               1 = write block, 0 = read block
//   cmd_base, cmd_len       first word address, word count (0..2^ADDR_W)
//   src_data/valid/ready    write-data input stream
//   snk_data/valid/ready    read-data output stream (FIFO head)
//   busy, done              command in progress, one-cycle completion pulse
//   checksum                modulo-2^DATA_W sum of transferred words
//   avm                     Avalon-MM master bus to the RAM slave

module onchip_mem_dma_master #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_base,
   input  logic [ADDR_W:0]     cmd_len,
   input  logic [DATA_W-1:0]   src_data,
   input  logic                src_valid,
   output logic                src_ready,
   output logic [DATA_W-1:0]   snk_data,
   output logic                snk_valid,
   input  logic                snk_ready,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   checksum,
   onchip_mem_dma_master_if.master avm
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_FLUSH,
      S_FINISH
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [ADDR_W:0]     remaining;
   logic                in_flight;

   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [CNT_W-1:0]    occupancy;

   logic accept;
   logic rem_nz;
   logic rd_issue;
   logic wr_issue;
   logic push;
   logic pop;

   assign accept    = cmd_valid & cmd_ready;
   assign rem_nz    = (remaining != '0);
   // Reserve a FIFO slot for the read still on the bus so its data always fits.
   assign occupancy = fifo_cnt + CNT_W'(in_flight);
   assign rd_issue  = (state == S_READ) && rem_nz && (occupancy < DEPTH_C);
   assign wr_issue  = (state == S_WRITE) && rem_nz && src_valid;
   // Read latency is fixed at one clock, so the returning word is simply the
   // read issued in the previous cycle.
   assign push      = in_flight;
   assign pop       = snk_valid & snk_ready;

   assign src_ready      = (state == S_WRITE) && rem_nz;
   assign snk_valid      = (fifo_cnt != '0);
   assign snk_data       = fifo_mem[rd_ptr];

   assign avm.chipselect = rd_issue | wr_issue;
   assign avm.write      = wr_issue;
   assign avm.address    = addr_cnt;
   assign avm.writedata  = wr_issue ? src_data : '0;
   assign avm.byteenable = '1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         addr_cnt  <= '0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  addr_cnt  <= cmd_base;
                  remaining <= cmd_len;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_len == '0) begin
                     state <= S_FINISH;
                     done  <= 1'b1;
                  end else begin
                     state <= cmd_write ? S_WRITE : S_READ;
                  end
               end
            end
            S_READ: begin
               if (rd_issue) begin
                  addr_cnt  <= addr_cnt + ADDR_ONE;
                  remaining <= remaining - REM_ONE;
                  if (remaining == REM_ONE) begin
                     state <= S_FLUSH;
                  end
               end
            end
            S_WRITE: begin
               if (wr_issue) begin
                  addr_cnt  <= addr_cnt + ADDR_ONE;
                  remaining <= remaining - REM_ONE;
                  if (remaining == REM_ONE) begin
                     state <= S_FINISH;
                     done  <= 1'b1;
                  end
               end
            end
            S_FLUSH: begin
               if (!in_flight && (fifo_cnt == '0)) begin
                  state <= S_FINISH;
                  done  <= 1'b1;
               end
            end
            S_FINISH: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_flight <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
      end else begin
         in_flight <= rd_issue;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // FIFO storage carries no reset; validity is tracked by fifo_cnt alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= avm.readdata;
      end
   end

`ifdef DMA_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;

   // Read words count when they land in the FIFO, write words when issued;
   // the two never coincide because they belong to different commands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= '0;
      end else if (accept) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_q + (push ? avm.readdata : '0) + (wr_issue ? src_data : '0);
      end
   end

   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: doc/onchip_mem_dma_master.md
Name: onchip_mem_dma_master

Overview:
- Avalon-MM master that drives the single-port on-chip RAM slave (address/byteenable/chipselect/write/writedata/readdata, no waitrequest, fixed read latency 1).
- Executes one command at a time: sequential block read streamed out, or sequential block write fed from a stream.
- Sits between the CPU-side control logic and the on-chip memory.
- Frees the processor from word-by-word copies of game/frame data.

Parameters:
- ADDR_W, 10, word address width; equals the slave address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- FIFO_DEPTH, 4, read-return FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1=write block, 0=read block.
- cmd_base  in  ADDR_W  first word address.
- cmd_len  in  ADDR_W+1  word count, 0..2^ADDR_W.
- src_data  in  DATA_W  write-stream data.
- src_valid  in  1  write-stream valid.
- src_ready  out  1  write-stream ready.
- snk_data  out  DATA_W  read-stream data (FIFO head).
- snk_valid  out  1  read-stream valid.
- snk_ready  in  1  read-stream ready.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- avm_address  out  ADDR_W  to slave address.
- avm_byteenable  out  DATA_W/8  constant all ones.
- avm_chipselect  out  1  access strobe.
- avm_write  out  1  write qualifier.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  from slave, valid 1 cycle after a read strobe.
- checksum  out  DATA_W  see Optional Feature.

Behaviour:
- Reset (async assert, sync deassert at clk) gives:
  - State IDLE, cmd_ready=1; busy=0, done=0.
  - avm_chipselect=0, avm_write=0; avm_address=0, avm_writedata=0.
  - src_ready=0, snk_valid=0, FIFO empty; checksum=0.
- States: IDLE, READ, WRITE, FLUSH, FINISH.
- Accept rule: command accepted on the cycle cmd_valid & cmd_ready.
  - cmd_base is latched into an address counter and cmd_len into a remaining counter.
  - busy=1 from the next cycle until done.
- cmd_len==0: go to FINISH. done=1 on the next cycle, no bus access, return to IDLE.
- READ:
  - A read is issued (chipselect=1, write=0, address=counter) in any cycle where remaining>0 and (FIFO occupancy + in-flight) < FIFO_DEPTH.
  - In-flight is at most 1. Each issue increments the address and decrements remaining.
  - avm_readdata is captured into the FIFO exactly one clk after each issue.
  - Back-to-back reads are allowed: 1 word/cycle sustained while snk_ready=1.
  - When remaining hits 0, go to FLUSH. FLUSH waits until in-flight=0 and the FIFO is empty.
  - Then FINISH: done=1 for one cycle, then IDLE.
- WRITE:
  - src_ready = (state==WRITE) & (remaining>0).
  - On src_valid & src_ready, in the same cycle: chipselect=1, write=1, writedata=src_data, address=counter. Then address++ and remaining--.
  - These are combinational from the registered counters and src_data; the slave samples them at the edge.
  - On the last accepted word, go to FINISH: done=1 in the following cycle.
- Address wrap: the counter wraps modulo 2^ADDR_W (base 0x3FE, len 4 → 0x3FE,0x3FF,0x000,0x001).
- snk side: snk_valid = FIFO non-empty and snk_data = FIFO head. A word pops on snk_valid & snk_ready.
  - Simultaneous push/pop in one cycle keeps occupancy unchanged.
- cmd_valid while busy is ignored (cmd_ready=0); no queuing.
- Mid-operation reset_n assertion aborts immediately to reset values.
  - No done pulse; partial writes already performed stay in memory.
- chipselect is never high outside READ/WRITE.

Optional Feature:
- Macro DMA_CHECKSUM_EN.
- Defined:
  - checksum accumulates the modulo-2^DATA_W sum of every word transferred: read words at FIFO push, write words at issue.
  - It clears to 0 on command accept and holds its value after done until the next accept.
- Undefined: checksum is tied to 0 and no accumulator is built.

Test Plan:
- Write base=0x010 len=3 with src words 0x11,0x22,0x33 and src_valid held high → three consecutive write strobes at 0x010–0x012, done pulse on the 4th cycle after accept, checksum=0x66 (macro on).
- Read base=0x010 len=3 with snk_ready=1 → snk data 0x11,0x22,0x33 in order, one word/cycle after the initial latency, done after the last pop.
- Read len=8 with snk_ready=0 → exactly 4 read strobes, then stall; raising snk_ready resumes reads, all 8 words delivered in order.
- Write base=0x3FE len=4 → addresses 0x3FE,0x3FF,0x000,0x001; readback of 0x000 returns the 3rd word.
- cmd_len=0 → no chipselect, done=1 exactly one cycle after accept; cmd_valid during busy is ignored.
- Assert reset_n low mid-read (after 2 of 6 words) → all outputs at reset values immediately, FIFO empty, no done, cmd_ready=1 after release.
